sd_window_sequencer: RTL and testbench
======================================

Name: sd_window_sequencer

Overview:
Sequences the sigma-delta ones-count measurement for the DAQ. Gates a sample counter and a ones accumulator over a programmable decimation window of N strobed bitstream samples. Sits between the modulator bitstream sampler and the readout logic, and delivers each window's ones count through a valid/ready result port. Supports single-shot and continuous back-to-back windows, with abort and overrun reporting.

Parameters:
CNT_WIDTH, 16, width of the ones count and of result; must be >= LEN_WIDTH (elaboration-time assertion).
LEN_WIDTH, 16, width of the window length config and of the internal sample counter.
TS_WIDTH, 32, width of the timestamp counter (used only with the optional feature).

Ports:
clk  in  1  single clock for the whole block; all logic on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
sd_strobe  in  1  qualifies sd_bit as a new sample this cycle.
sd_bit  in  1  modulator bitstream sample.
start  in  1  level-sampled start request.
stop  in  1  abort the current window.
cfg_len  in  LEN_WIDTH  window length N in samples; sampled only when start is accepted.
cfg_continuous  in  1  1 = restart windows back-to-back; sampled only when start is accepted.
busy  out  1  high in ACCUM.
cfg_err  out  1  one-cycle pulse when start is rejected.
result  out  CNT_WIDTH  ones count of the last completed window.
result_valid  out  1  result holds unread data.
result_ready  in  1  consumer accepts result.
overrun  out  1  sticky flag: an unread result was overwritten.
result_ts  out  TS_WIDTH  timestamp of window completion; tied to 0 without the optional feature.

Behaviour:
- Reset: asynchronous. State goes to IDLE. busy, cfg_err, result, result_valid, overrun, result_ts and all internal counters go to 0. Reset asserted mid-window discards the partial window.
- State IDLE:
  - start=1 and cfg_len!=0: latch len_q=cfg_len and cont_q=cfg_continuous, clear the sample and ones counters, clear overrun, go to ACCUM. busy=1 from the next cycle.
  - start=1 and cfg_len==0: stay in IDLE; pulse cfg_err for 1 cycle.
- State ACCUM:
  - On each cycle with sd_strobe=1: sample_cnt increments and ones_cnt increments by sd_bit.
  - Completion is a strobe cycle with sample_cnt==len_q-1. On that edge, result is loaded with ones_cnt+sd_bit (the current bit is included) and result_valid=1.
  - At completion with cont_q=1: both counters clear and ACCUM continues with zero dead cycles. A strobe on the cycle after completion is sample 0 of the next window.
  - At completion with cont_q=0: go to IDLE.
  - stop=1: go to IDLE next cycle and discard the partial window. stop wins over a same-cycle completion; no result is produced.
  - start is ignored in ACCUM.
  - sd_strobe=0 cycles leave the counters unchanged.
- Latency: result_valid rises on the clock edge of the completing strobe, i.e. it is visible the cycle after that strobe.
- Result handshake:
  - result_valid stays high until a cycle with result_ready=1, then drops next cycle unless a new completion occurs in that same cycle.
  - Completion with result_valid=1 and result_ready=0: result is overwritten with the new data, result_valid stays 1, overrun is set.
  - Completion with result_valid=1 and result_ready=1: new data is loaded, result_valid stays 1, no overrun.
  - overrun clears only on reset or on an accepted start.
- Width rules:
  - ones count <= N <= 2^LEN_WIDTH-1, so ones_cnt never wraps.
  - sample_cnt never exceeds len_q-1.
  - N=1 is legal: every strobe completes a window.

Optional Feature:
SD_WINDOW_TIMESTAMP_EN
- Defined: a free-running TS_WIDTH counter increments every clk, is cleared by reset, and wraps modulo 2^TS_WIDTH. Its value on the completion edge is captured into result_ts together with result.
- Undefined: no timestamp counter is built; result_ts is constant 0.

Decomposition:
- Package sd_daq_pkg:
  - typedef enum sd_win_state_e {SD_WIN_IDLE, SD_WIN_ACCUM}.
  - localparam defaults for CNT_WIDTH, LEN_WIDTH and TS_WIDTH.
- Sub-module sd_window_timer: loadable sample counter with strobe input and clear input, producing a last_sample pulse. Instantiated once in sd_window_sequencer.

Test Plan:
1. cfg_len=8, single-shot, bits 1,0,1,1,0,0,1,1 on 8 consecutive strobes -> result=5, result_valid=1 the cycle after the 8th strobe, busy=0, state IDLE.
2. cfg_len=4, continuous, all-ones stream, strobe every 3rd cycle, result_ready held 1 -> result=4 every 12 cycles, overrun stays 0, no samples dropped between windows.
3. cfg_len=2, continuous, result_ready=0 -> result_valid=1, second completion overwrites result and sets overrun=1; a later start clears overrun.
4. start with cfg_len=0 -> cfg_err high exactly 1 cycle, busy stays 0. Then cfg_len=1 with sd_bit=1 on one strobe -> result=1.
5. cfg_len=8, stop asserted on the same cycle as the 8th strobe -> no result_valid, IDLE next cycle. Also: reset_n low at sample 3 -> all outputs 0 immediately.
6. With SD_WINDOW_TIMESTAMP_EN defined, cfg_len=4, strobes on cycles 10..13 after reset -> result_ts equals the timestamp counter at the cycle-13 edge. Without the macro, result_ts=0.

Source files
------------

// File: rtl/sd_daq_pkg.sv
// Shared types and default widths for the sigma-delta DAQ window logic.
package sd_daq_pkg;

  localparam int SD_CNT_WIDTH = 16;
  localparam int SD_LEN_WIDTH = 16;
  localparam int SD_TS_WIDTH  = 32;

  typedef enum logic {
    SD_WIN_IDLE,
    SD_WIN_ACCUM
  } sd_win_state_e;

endpackage

// File: rtl/sd_window_timer.sv
// Loadable window sample counter: counts qualified strobes and flags the last
// sample of a window of len samples, wrapping to 0 on that sample.
module sd_window_timer
  import sd_daq_pkg::*;
#(
  parameter int LEN_WIDTH = SD_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 clear,
  input  logic                 strobe,
  output logic                 last_sample
);

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] sample_cnt;

  // len_q is never 0 while strobes are passed in, so len_q-1 cannot underflow.
  assign last_sample = strobe && (sample_cnt == len_q - LEN_WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= '0;
      sample_cnt <= '0;
    end else if (load) begin
      len_q      <= len;
      sample_cnt <= '0;
    end else if (clear || last_sample) begin
      sample_cnt <= '0;
    end else if (strobe) begin
      sample_cnt <= sample_cnt + LEN_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sd_window_sequencer.sv
// Sigma-delta ones-count window sequencer with valid/ready result port.
// Optional completion timestamp when SD_WINDOW_TIMESTAMP_EN is defined.
module sd_window_sequencer
  import sd_daq_pkg::*;
#(
  parameter int CNT_WIDTH = SD_CNT_WIDTH,
  parameter int LEN_WIDTH = SD_LEN_WIDTH,
  parameter int TS_WIDTH  = SD_TS_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sd_strobe,
  input  logic                 sd_bit,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_continuous,
  output logic                 busy,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 overrun,
  output logic [TS_WIDTH-1:0]  result_ts
);

  if (CNT_WIDTH < LEN_WIDTH) begin : g_width_check
    $error("sd_window_sequencer: CNT_WIDTH must be >= LEN_WIDTH");
  end

  sd_win_state_e        state, state_nxt;
  logic                 accept, reject, complete;
  logic                 strobe_act, abort, last_sample;
  logic                 cont_q;
  logic [CNT_WIDTH-1:0] ones_cnt;

  assign strobe_act = (state == SD_WIN_ACCUM) && sd_strobe;
  assign abort      = (state == SD_WIN_ACCUM) && stop;
  assign busy       = (state == SD_WIN_ACCUM);

  sd_window_timer #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (accept),
    .len        (cfg_len),
    .clear      (abort),
    .strobe     (strobe_act),
    .last_sample(last_sample)
  );

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    complete  = 1'b0;
    case (state)
      SD_WIN_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            accept    = 1'b1;
            state_nxt = SD_WIN_ACCUM;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SD_WIN_ACCUM: begin
        // stop beats a same-cycle completion: the window is simply dropped.
        if (stop) begin
          state_nxt = SD_WIN_IDLE;
        end else if (last_sample) begin
          complete = 1'b1;
          if (!cont_q) state_nxt = SD_WIN_IDLE;
        end
      end
      default: state_nxt = SD_WIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SD_WIN_IDLE;
      cont_q   <= 1'b0;
      ones_cnt <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= reject;
      if (accept) begin
        cont_q   <= cfg_continuous;
        ones_cnt <= '0;
      end else if (abort || complete) begin
        ones_cnt <= '0;
      end else if (strobe_act) begin
        ones_cnt <= ones_cnt + CNT_WIDTH'(sd_bit);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (complete) begin
        result       <= ones_cnt + CNT_WIDTH'(sd_bit);
        result_valid <= 1'b1;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
      if (accept) begin
        overrun <= 1'b0;
      end else if (complete && result_valid && !result_ready) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SD_WINDOW_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt    <= '0;
      result_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (complete) result_ts <= ts_cnt;
    end
  end
`else
  assign result_ts = {TS_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_sd_window_sequencer.sv
// Directed self-checking bench for sd_window_sequencer; expected window
// results are queued when the completing strobe is driven.
module tb_sd_window_sequencer;

  localparam int CW = 16;
  localparam int LW = 16;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sd_strobe = 1'b0;
  logic          sd_bit = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_continuous = 1'b0;
  logic          busy;
  logic          cfg_err;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          overrun;
  logic [TW-1:0] result_ts;

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];
  logic [TW-1:0] ts_model;
  logic [TW-1:0] exp_ts;

  sd_window_sequencer #(.CNT_WIDTH(CW), .LEN_WIDTH(LW), .TS_WIDTH(TW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sd_strobe     (sd_strobe),
    .sd_bit        (sd_bit),
    .start         (start),
    .stop          (stop),
    .cfg_len       (cfg_len),
    .cfg_continuous(cfg_continuous),
    .busy          (busy),
    .cfg_err       (cfg_err),
    .result        (result),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .overrun       (overrun),
    .result_ts     (result_ts)
  );

  always #5 clk = ~clk;

  // Reference free-running cycle counter for the timestamp check.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_model <= '0;
    else          ts_model <= ts_model + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [CW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=result expected=empty_scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(result_valid), 64'd1);
      check({tag, "_result"}, 64'(result), 64'(e));
    end
  endtask

  task automatic do_start(input logic [LW-1:0] len, input logic cont);
    start = 1'b1; cfg_len = len; cfg_continuous = cont;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_strobe(input logic b);
    sd_strobe = 1'b1; sd_bit = b;
    tick();
    sd_strobe = 1'b0; sd_bit = 1'b0;
  endtask

  initial begin
    logic [7:0] bits1;
    int         ones;
    bits1 = 8'b1100_1101;  // bit i is sample i: 1,0,1,1,0,0,1,1

    #12 reset_n = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_valid", 64'(result_valid), 0);
    check("rst_result", 64'(result), 0);
    check("rst_overrun", 64'(overrun), 0);
    check("rst_cfg_err", 64'(cfg_err), 0);
    check("rst_ts", 64'(result_ts), 0);

    // 1: single-shot, N=8
    tick();
    do_start(8, 1'b0);
    check("t1_busy_start", 64'(busy), 1);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      ones += int'(bits1[i]);
      if (i == 7) exp_q.push_back(CW'(ones));
      if (i == 7) check("t1_no_early_valid", 64'(result_valid), 0);
      drive_strobe(bits1[i]);
    end
    pop_check("t1");
    check("t1_busy_done", 64'(busy), 0);
    tick();
    check("t1_valid_held", 64'(result_valid), 1);
    result_ready = 1'b1;
    tick();
    check("t1_valid_drop", 64'(result_valid), 0);

    // 2: continuous, N=4, all ones, strobe every 3rd cycle, ready held high
    do_start(4, 1'b1);
    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < 4; s++) begin
        if (s == 3) exp_q.push_back(CW'(4));
        drive_strobe(1'b1);
        if (s == 3) pop_check($sformatf("t2_w%0d", w));
        tick();
        tick();
      end
      check($sformatf("t2_w%0d_valid_drop", w), 64'(result_valid), 0);
      check($sformatf("t2_w%0d_busy", w), 64'(busy), 1);
      check($sformatf("t2_w%0d_overrun", w), 64'(overrun), 0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("t2_stop_idle", 64'(busy), 0);

    // 3: continuous N=2, back-to-back strobes, ready low -> overrun
    result_ready = 1'b0;
    do_start(2, 1'b1);
    drive_strobe(1'b1);
    exp_q.push_back(CW'(2));
    drive_strobe(1'b1);
    pop_check("t3_w0");
    check("t3_w0_overrun", 64'(overrun), 0);
    drive_strobe(1'b0);
    exp_q.push_back(CW'(1));
    drive_strobe(1'b1);
    pop_check("t3_w1");
    check("t3_w1_overrun", 64'(overrun), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t3_overrun_sticky", 64'(overrun), 1);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    check("t3_drained", 64'(result_valid), 0);
    do_start(2, 1'b0);
    check("t3_start_clears_overrun", 64'(overrun), 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // 4: rejected start, then N=1
    do_start(0, 1'b0);
    check("t4_cfg_err_pulse", 64'(cfg_err), 1);
    check("t4_busy_low", 64'(busy), 0);
    tick();
    check("t4_cfg_err_once", 64'(cfg_err), 0);
    check("t4_still_idle", 64'(busy), 0);
    do_start(1, 1'b0);
    exp_q.push_back(CW'(1));
    drive_strobe(1'b1);
    pop_check("t4_n1");
    check("t4_n1_idle", 64'(busy), 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;

    // 5: stop on the completing strobe, then reset mid-window
    do_start(8, 1'b0);
    for (int i = 0; i < 7; i++) drive_strobe(1'b1);
    stop = 1'b1; drive_strobe(1'b1); stop = 1'b0;
    check("t5_stop_no_valid", 64'(result_valid), 0);
    check("t5_stop_idle", 64'(busy), 0);
    tick();
    check("t5_stop_result_kept", 64'(result), 1);
    do_start(8, 1'b0);
    for (int i = 0; i < 3; i++) drive_strobe(1'b1);
    sd_strobe = 1'b1; sd_bit = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 0);
    check("t5_rst_result", 64'(result), 0);
    check("t5_rst_valid", 64'(result_valid), 0);
    check("t5_rst_overrun", 64'(overrun), 0);
    check("t5_rst_cfg_err", 64'(cfg_err), 0);
    check("t5_rst_ts", 64'(result_ts), 0);
    sd_strobe = 1'b0; sd_bit = 1'b0;
    #3 reset_n = 1'b1;

    // 6: completion timestamp
    for (int i = 0; i < 6; i++) tick();
    do_start(4, 1'b0);
    drive_strobe(1'b1);
    drive_strobe(1'b0);
    drive_strobe(1'b1);
    exp_ts = ts_model;
    exp_q.push_back(CW'(3));
    drive_strobe(1'b1);
    pop_check("t6");
`ifdef SD_WINDOW_TIMESTAMP_EN
    check("t6_ts", 64'(result_ts), 64'(exp_ts));
    check("t6_ts_nonzero", 64'(result_ts != '0), 1);
`else
    check("t6_ts_zero", 64'(result_ts), 0);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
